// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave
// protocol sequencer.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    NOMATCH,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_ACK,
    WAIT_STOP
  } i2c_state_t;

  localparam logic       ACK       = 1'b0;
  localparam logic       NACK      = 1'b1;
  localparam logic [3:0] BYTE_BITS = 4'd8;

endpackage

// File: rtl/i2c_shift_reg.sv
// 8-bit MSB-first shift register with parallel load,
// serial shift-in and shift-out enables.
module i2c_shift_reg (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] din_i,
  input  logic       shift_in_en_i,
  input  logic       shift_out_en_i,
  input  logic       sin_i,
  output logic [7:0] q_o
);

  logic [7:0] q_q;

  // Load has priority; shift-out pads with zero.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i)
      q_q <= '0;
    else if (load_i)
      q_q <= din_i;
    else if (shift_in_en_i)
      q_q <= {q_q[6:0], sin_i};
    else if (shift_out_en_i)
      q_q <= {q_q[6:0], 1'b0};
  end

  assign q_o = q_q;

endmodule

// File: rtl/i2c_slave_controller.sv
// Slave-side I2C sequencer: address match, ACK/NACK,
// byte receive into RX FIFO and transmit from TX FIFO.
module i2c_slave_controller
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rising_edge_found,
  input  logic       falling_edge_found,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       sda_in,
  input  logic       rx_full,
  input  logic       tx_empty,
  input  logic [7:0] tx_data,
  output logic       sda_out_en,
  output logic       sda_out,
  output logic [7:0] rx_data,
  output logic       rx_write,
  output logic       tx_read,
  output logic       rw_mode,
  output logic       busy
);

  i2c_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic       en_q, en_d;
  logic       sda_q, sda_d;
  logic [7:0] rxd_q, rxd_d;
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic       pend_q, pend_d;
  logic       ok_q, ok_d;
  logic       ack_q, ack_d;

  logic       rise, fall, ok_now;
  logic       load, sh_in, sh_out;
  logic [7:0] ld_val, sh;

  // Simultaneous edges are a front-end error: drop both.
  assign rise   = rising_edge_found & ~falling_edge_found;
  assign fall   = falling_edge_found & ~rising_edge_found;
  assign ld_val = tx_empty ? IDLE_BYTE : tx_data;
  assign ok_now = pend_q ? ~rx_full : ok_q;

  i2c_shift_reg u_sh (
    .clk           (clk),
    .rst_i         (n_rst),
    .load_i        (load),
    .din_i         (ld_val),
    .shift_in_en_i (sh_in),
    .shift_out_en_i(sh_out),
    .sin_i         (sda_in),
    .q_o           (sh)
  );

  // Next-state, counter and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    en_d    = en_q;
    sda_d   = sda_q;
    rxd_d   = rxd_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    pend_d  = 1'b0;
    ok_d    = ok_q;
    ack_d   = ack_q;
    load    = 1'b0;
    sh_in   = 1'b0;
    sh_out  = 1'b0;
    if (start_found) begin
      state_d = ADDR;
      cnt_d   = '0;
      en_d    = 1'b0;
      ack_d   = 1'b0;
    end else if (stop_found) begin
      state_d = IDLE;
      en_d    = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (rise && cnt_q < BYTE_BITS) begin
            sh_in = 1'b1;
            cnt_d = cnt_q + 4'd1;
          end
          if (fall && cnt_q == BYTE_BITS) begin
            if (sh[7:1] == SLAVE_ADDR) begin
              rw_d    = sh[0];
              en_d    = 1'b1;
              sda_d   = ACK;
              state_d = ADDR_ACK;
            end else begin
              state_d = NOMATCH;
            end
          end
        end
        ADDR_ACK: begin
          if (fall) begin
            cnt_d = '0;
            if (!rw_q) begin
              en_d    = 1'b0;
              state_d = RX_BYTE;
            end else begin
              load    = 1'b1;
              rd_d    = ~tx_empty;
              en_d    = 1'b1;
              sda_d   = ld_val[7];
              state_d = TX_BYTE;
            end
          end
        end
        RX_BYTE: begin
          if (rise && cnt_q < BYTE_BITS) begin
            sh_in  = 1'b1;
            cnt_d  = cnt_q + 4'd1;
            pend_d = (cnt_q == BYTE_BITS - 4'd1);
          end
          if (pend_q) begin
            rxd_d = sh;
            wr_d  = ~rx_full;
            ok_d  = ~rx_full;
          end
          if (fall && cnt_q == BYTE_BITS) begin
            state_d = RX_ACK;
            en_d    = ok_now;
            sda_d   = ACK;
          end
        end
        RX_ACK: begin
          if (fall) begin
            en_d    = 1'b0;
            cnt_d   = '0;
            state_d = RX_BYTE;
          end
        end
        TX_BYTE: begin
          if (fall) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == BYTE_BITS - 4'd1) begin
              en_d    = 1'b0;
              ack_d   = 1'b0;
              state_d = TX_ACK;
            end else begin
              sh_out = 1'b1;
              sda_d  = sh[6];
            end
          end
        end
        TX_ACK: begin
          if (rise) begin
            if (sda_in == NACK)
              state_d = WAIT_STOP;
            else
              ack_d = 1'b1;
          end
          if (fall && ack_q) begin
            load    = 1'b1;
            rd_d    = ~tx_empty;
            en_d    = 1'b1;
            sda_d   = ld_val[7];
            cnt_d   = '0;
            ack_d   = 1'b0;
            state_d = TX_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs; reset releases SDA at once.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      en_q    <= 1'b0;
      sda_q   <= 1'b0;
      rxd_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      pend_q  <= 1'b0;
      ok_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      en_q    <= en_d;
      sda_q   <= sda_d;
      rxd_q   <= rxd_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      pend_q  <= pend_d;
      ok_q    <= ok_d;
      ack_q   <= ack_d;
    end
  end

  assign sda_out_en = en_q;
  assign sda_out    = sda_q;
  assign rx_data    = rxd_q;
  assign rx_write   = wr_q;
  assign tx_read    = rd_q;
  assign rw_mode    = rw_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Directed bench for the I2C slave sequencer.
// Master side is modelled by edge/start/stop pulses.
module tb_i2c_slave_controller;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       rise = 1'b0, fall = 1'b0;
  logic       start = 1'b0, stop = 1'b0;
  logic       sda_in = 1'b1;
  logic       rx_full = 1'b0, tx_empty = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sda_out_en, sda_out, rx_write, tx_read;
  logic       rw_mode, busy;
  logic [7:0] rx_data;

  int n_chk = 0, n_pass = 0;
  int wr_cnt = 0, rd_cnt = 0;
  logic en_seen = 1'b0;
  logic s;
  logic [7:0] b;

  i2c_slave_controller dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .rising_edge_found (rise),
    .falling_edge_found(fall),
    .start_found       (start),
    .stop_found        (stop),
    .sda_in            (sda_in),
    .rx_full           (rx_full),
    .tx_empty          (tx_empty),
    .tx_data           (tx_data),
    .sda_out_en        (sda_out_en),
    .sda_out           (sda_out),
    .rx_data           (rx_data),
    .rx_write          (rx_write),
    .tx_read           (tx_read),
    .rw_mode           (rw_mode),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_write) wr_cnt++;
    if (tx_read) rd_cnt++;
    if (sda_out_en) en_seen = 1'b1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic clr();
    wr_cnt  = 0;
    rd_cnt  = 0;
    en_seen = 1'b0;
  endtask

  // One SCL period; returns the bus level seen at SCL rise.
  task automatic clock_bit(input logic bi, output logic so);
    sda_in = bi;
    @(negedge clk);
    rise = 1'b1;
    @(negedge clk);
    so = sda_out_en ? sda_out : 1'b1;
    rise = 1'b0;
    @(negedge clk);
    fall = 1'b1;
    @(negedge clk);
    fall = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    logic x;
    for (int i = 7; i >= 0; i--) clock_bit(v[i], x);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic x;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, x);
      v = {v[6:0], x};
    end
  endtask

  task automatic start_cond();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    fall = 1'b1;
    @(negedge clk);
    fall = 1'b0;
    @(negedge clk);
  endtask

  task automatic stop_cond();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(sda_out_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rxd", 32'(rx_data), 0);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0x3C, data 0xA5
    clr();
    start_cond();
    send_byte(8'h78);
    clock_bit(1'b1, s);
    chk("w_addr_ack", 32'(s), 0);
    send_byte(8'hA5);
    clock_bit(1'b1, s);
    chk("w_data_ack", 32'(s), 0);
    stop_cond();
    chk("w_rxd", 32'(rx_data), 32'hA5);
    chk("w_wrcnt", wr_cnt, 1);
    chk("w_busy", 32'(busy), 0);

    // Address 0x22 write: no match
    clr();
    start_cond();
    send_byte(8'h44);
    clock_bit(1'b1, s);
    chk("nm_state", 32'(dut.state_q), 32'(NOMATCH));
    send_byte(8'h5A);
    clock_bit(1'b1, s);
    chk("nm_state2", 32'(dut.state_q), 32'(NOMATCH));
    stop_cond();
    chk("nm_en", 32'(en_seen), 0);
    chk("nm_wr", wr_cnt, 0);
    chk("nm_idle", 32'(busy), 0);

    // Read 0x3C: two bytes, ACK then NACK
    clr();
    tx_data = 8'h5A;
    start_cond();
    send_byte(8'h79);
    clock_bit(1'b1, s);
    chk("r_addr_ack", 32'(s), 0);
    chk("r_rw", 32'(rw_mode), 1);
    tx_data = 8'hC3;
    read_byte(b);
    chk("r_byte1", 32'(b), 32'h5A);
    clock_bit(ACK, s);
    read_byte(b);
    chk("r_byte2", 32'(b), 32'hC3);
    clock_bit(NACK, s);
    chk("r_wait", 32'(dut.state_q), 32'(WAIT_STOP));
    chk("r_rdcnt", rd_cnt, 2);
    stop_cond();

    // Read with TX FIFO empty
    clr();
    tx_empty = 1'b1;
    start_cond();
    send_byte(8'h79);
    clock_bit(1'b1, s);
    read_byte(b);
    chk("e_byte", 32'(b), 32'hFF);
    clock_bit(NACK, s);
    chk("e_rdcnt", rd_cnt, 0);
    stop_cond();
    tx_empty = 1'b0;

    // Write with RX FIFO full
    clr();
    rx_full = 1'b1;
    start_cond();
    send_byte(8'h78);
    clock_bit(1'b1, s);
    chk("f_addr_ack", 32'(s), 0);
    send_byte(8'h33);
    clock_bit(1'b1, s);
    chk("f_nack", 32'(s), 1);
    chk("f_wrcnt", wr_cnt, 0);
    stop_cond();
    rx_full = 1'b0;

    // Repeated START after 4 data bits
    clr();
    start_cond();
    send_byte(8'h78);
    clock_bit(1'b1, s);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rs_state", 32'(dut.state_q), 32'(ADDR));
    chk("rs_cnt", 32'(dut.cnt_q), 0);
    chk("rs_en", 32'(sda_out_en), 0);
    @(negedge clk);
    fall = 1'b1;
    @(negedge clk);
    fall = 1'b0;
    send_byte(8'h78);
    clock_bit(1'b1, s);
    chk("rs_ack", 32'(s), 0);
    send_byte(8'h81);
    clock_bit(1'b1, s);
    chk("rs_rxd", 32'(rx_data), 32'h81);
    chk("rs_wrcnt", wr_cnt, 1);
    stop_cond();

    // Reset asserted while slave drives address ACK
    start_cond();
    send_byte(8'h78);
    chk("ra_pre", 32'(sda_out_en), 1);
    #2;
    n_rst = 1'b1;
    #1;
    chk("ra_en", 32'(sda_out_en), 0);
    chk("ra_busy", 32'(busy), 0);
    chk("ra_outs", {rx_data, sda_out, rx_write,
                    tx_read, rw_mode}, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
